// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the clear-sequencer state encoding for regfile_mp.
package regfile_pkg;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DEPTH      = 32;
    localparam int unsigned DEF_NR         = 2;
    localparam int unsigned DEF_NW         = 1;

    // CLEAR zeroes the array after reset; RUN is terminal until the next reset.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/issue bus of the multi-port register file.
// master = core side (decode/writeback), slave = register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned NR         = DEF_NR,
    parameter int unsigned NW         = DEF_NW
);

    logic                     ready;
    logic [NR*ADDR_WIDTH-1:0] rd_addr;
    logic [NR*WIDTH-1:0]      rd_dout;
    logic [NR-1:0]            rd_pending;
    logic [NW-1:0]            wr_en;
    logic [NW*ADDR_WIDTH-1:0] wr_addr;
    logic [NW*WIDTH-1:0]      wr_din;
    logic                     issue_en;
    logic [ADDR_WIDTH-1:0]    issue_addr;

    modport master (
        input  ready, rd_dout, rd_pending,
        output rd_addr, wr_en, wr_addr, wr_din, issue_en, issue_addr
    );

    modport slave (
        output ready, rd_dout, rd_pending,
        input  rd_addr, wr_en, wr_addr, wr_din, issue_en, issue_addr
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: post-reset sequencer that walks the array index 0..DEPTH-1
// (one per cycle) issuing zero writes, then raises ready and stays in RUN.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_d;

    // State, counter and registered ready; reset restarts the clear at index 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready   <= ready_d;
        end
    end

    // Next-state and clear-write decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = CLEAR;
                ready_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NR combinational read ports, NW synchronous write ports, x0 hard-wired
// to zero, per-register pending scoreboard and a post-reset clear sequence.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned NR         = DEF_NR,
    parameter int unsigned NW         = DEF_NW
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;

    logic                  ready;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic [ADDR_WIDTH-1:0] rd_a [NR];
    logic [ADDR_WIDTH-1:0] wr_a [NW];
    logic [WIDTH-1:0]      wr_d [NW];
    logic [NW-1:0]         wr_ok;
    logic                  iss_ok;

    logic [NR*WIDTH-1:0]   rd_dout_c;
    logic [NR-1:0]         rd_pending_c;

    // True when the address names a physical register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    regfile_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Unpack port buses and qualify writes/issue: only in RUN, never x0, never out of range.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rd_a[i] = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int p = 0; p < NW; p++) begin
            wr_a[p]  = bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            wr_d[p]  = bus.wr_din[p*WIDTH +: WIDTH];
            wr_ok[p] = ready && bus.wr_en[p] && (wr_a[p] != '0) && addr_ok(wr_a[p]);
        end
        iss_ok = ready && bus.issue_en && (bus.issue_addr != '0) && addr_ok(bus.issue_addr);
    end

    // Array write; later ports override earlier ones so the highest index wins a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end
        for (int p = 0; p < NW; p++) begin
            if (wr_ok[p]) begin
                mem[wr_a[p]] <= wr_d[p];
            end
        end
    end

    // Scoreboard next state: writebacks clear, issue sets afterwards so it wins.
    always_comb begin
        pending_d = pending_q;
        for (int p = 0; p < NW; p++) begin
            if (wr_ok[p]) begin
                pending_d[wr_a[p]] = 1'b0;
            end
        end
        if (iss_ok) begin
            pending_d[bus.issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Read muxes: zero while clearing, for x0 and for out-of-range addresses.
    always_comb begin
        rd_dout_c    = '0;
        rd_pending_c = '0;
        for (int i = 0; i < NR; i++) begin
            if (ready && (rd_a[i] != '0) && addr_ok(rd_a[i])) begin
                rd_dout_c[i*WIDTH +: WIDTH] = mem[rd_a[i]];
                rd_pending_c[i]             = pending_q[rd_a[i]];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NW; p++) begin
                    if (wr_ok[p] && (wr_a[p] == rd_a[i])) begin
                        rd_dout_c[i*WIDTH +: WIDTH] = wr_d[p];
                        rd_pending_c[i]             = iss_ok && (bus.issue_addr == rd_a[i]);
                    end
                end
`endif
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.rd_dout    = rd_dout_c;
    assign bus.rd_pending = rd_pending_c;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized bench with a behavioural register-file model, a per-cycle
// compare process, and directed literal checks for the key scenarios.
module tb_regfile_mp;

    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned D  = 24;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NR(NR), .NW(NW)) bus_if ();

    regfile_mp #(
        .WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(D), .NR(NR), .NW(NW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_mem  [D];
    bit           m_pend [D];
    int           clear_left = D;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            clear_left = D;
            for (int r = 0; r < D; r++) m_pend[r] = 1'b0;
        end else if (clear_left > 0) begin
            m_mem[D - clear_left] = '0;
            clear_left--;
        end else begin
            for (int p = 0; p < NW; p++) begin
                int a;
                a = int'(bus_if.wr_addr[p*AW +: AW]);
                if (bus_if.wr_en[p] && a != 0 && a < D) begin
                    m_mem[a]  = bus_if.wr_din[p*W +: W];
                    m_pend[a] = 1'b0;
                end
            end
            if (bus_if.issue_en && int'(bus_if.issue_addr) != 0 && int'(bus_if.issue_addr) < D)
                m_pend[int'(bus_if.issue_addr)] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        check("ready", W'(bus_if.ready), W'(clear_left == 0));
        for (int i = 0; i < NR; i++) begin
            int           a;
            logic [W-1:0] ed;
            logic         ep;
            a  = int'(bus_if.rd_addr[i*AW +: AW]);
            ed = '0;
            ep = 1'b0;
            if (clear_left == 0 && a != 0 && a < D) begin
                ed = m_mem[a];
                ep = m_pend[a];
`ifdef REGFILE_BYPASS_EN
                for (int p = 0; p < NW; p++) begin
                    if (bus_if.wr_en[p] && int'(bus_if.wr_addr[p*AW +: AW]) == a) begin
                        ed = bus_if.wr_din[p*W +: W];
                        ep = bus_if.issue_en && int'(bus_if.issue_addr) == a;
                    end
                end
`endif
            end
            check("rd_dout", bus_if.rd_dout[i*W +: W], ed);
            check("rd_pending", W'(bus_if.rd_pending[i]), W'(ep));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.wr_en    = '0;
        bus_if.issue_en = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        bus_if.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [W-1:0] d);
        bus_if.wr_en[p]           = 1'b1;
        bus_if.wr_addr[p*AW +: AW] = AW'(a);
        bus_if.wr_din[p*W +: W]    = d;
    endtask

    task automatic issue(input int a);
        bus_if.issue_en   = 1'b1;
        bus_if.issue_addr = AW'(a);
    endtask

    function automatic logic [W-1:0] rd(input int p);
        return bus_if.rd_dout[p*W +: W];
    endfunction

    task automatic randomize_inputs();
        int hot;
        hot = $urandom_range(1, 31);
        for (int p = 0; p < NW; p++) begin
            bus_if.wr_en[p]            = ($urandom_range(0, 2) != 0);
            bus_if.wr_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(hot) : AW'($urandom_range(0, 31));
            bus_if.wr_din[p*W +: W]    = $urandom;
        end
        bus_if.issue_en   = ($urandom_range(0, 2) == 0);
        bus_if.issue_addr = ($urandom_range(0, 3) == 0) ? AW'(hot) : AW'($urandom_range(0, 31));
        for (int i = 0; i < NR; i++)
            set_rd(i, ($urandom_range(0, 3) == 0) ? hot : int'($urandom_range(0, 31)));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus_if.rd_addr    = '0;
        bus_if.wr_en      = '0;
        bus_if.wr_addr    = '0;
        bus_if.wr_din     = '0;
        bus_if.issue_en   = 1'b0;
        bus_if.issue_addr = '0;
        for (int r = 0; r < D; r++) m_pend[r] = 1'b0;

        repeat (2) step();
        @(negedge clk);
        check("reset_ready", W'(bus_if.ready), W'(0));

        // Release reset with writes/issues pending that must be ignored while clearing.
        step();
        rst = 1'b1;
        set_wr(0, 5, 32'hFFFF_FFFF);
        issue(9);
        set_rd(0, 5);
        set_rd(1, 9);
        for (int k = 1; k <= int'(D); k++) begin
            step();
            check("clear_ready", W'(bus_if.ready), W'(k == int'(D)));
        end
        idle();
        @(negedge clk);
        check("clear_x5_zero", rd(0), 32'h0);
        check("clear_x9_pend", W'(bus_if.rd_pending[1]), W'(0));

        // Basic write/read and x0 discard.
        set_wr(0, 5, 32'hDEAD_BEEF);
        step(); idle(); set_rd(1, 5);
        @(negedge clk);
        check("x5_write", rd(1), 32'hDEAD_BEEF);
        set_wr(0, 0, 32'h0000_1234);
        step(); idle(); set_rd(0, 0);
        @(negedge clk);
        check("x0_zero", rd(0), 32'h0);

        // Two ports hit x7: port 1 wins.
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        step(); idle(); set_rd(0, 7);
        @(negedge clk);
        check("x7_collision", rd(0), 32'h22);

        // Scoreboard: issue, writeback+issue (set wins), writeback alone.
        issue(9);
        step(); idle(); set_rd(1, 9);
        @(negedge clk);
        check("x9_issued", W'(bus_if.rd_pending[1]), W'(1));
        set_wr(0, 9, 32'h0ABC);
        issue(9);
        step(); idle();
        @(negedge clk);
        check("x9_set_wins", W'(bus_if.rd_pending[1]), W'(1));
        set_wr(1, 9, 32'h0DEF);
        step(); idle();
        @(negedge clk);
        check("x9_cleared", W'(bus_if.rd_pending[1]), W'(0));
        check("x9_data", rd(1), 32'h0DEF);

        // Same-cycle read of a register being written.
        set_wr(0, 3, 32'h77);
        step(); idle();
        set_wr(0, 3, 32'hA5A5_A5A5);
        set_rd(0, 3);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("x3_same_cycle", rd(0), 32'hA5A5_A5A5);
`else
        check("x3_same_cycle", rd(0), 32'h77);
`endif
        step(); idle();
        @(negedge clk);
        check("x3_next_cycle", rd(0), 32'hA5A5_A5A5);

        // Top register and out-of-range accesses.
        set_wr(0, 30, 32'h3030);
        set_wr(1, D - 1, 32'h2323);
        issue(30);
        step(); idle();
        set_rd(0, 30);
        set_rd(1, D - 1);
        @(negedge clk);
        check("oor_data", rd(0), 32'h0);
        check("oor_pend", W'(bus_if.rd_pending[0]), W'(0));
        check("top_reg", rd(1), 32'h2323);

        // Random traffic.
        repeat (1500) begin
            randomize_inputs();
            step();
        end

        // Reset mid-run: immediate drop, then a full clear.
        randomize_inputs();
        rst = 1'b0;
        #1;
        check("midrst_ready", W'(bus_if.ready), W'(0));
        check("midrst_pend0", W'(bus_if.rd_pending[0]), W'(0));
        check("midrst_pend1", W'(bus_if.rd_pending[1]), W'(0));
        step();
        rst = 1'b1;
        idle();
        repeat (D) step();
        check("reclear_ready", W'(bus_if.ready), W'(1));
        for (int a = 0; a < 32; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            @(negedge clk);
            check("reclear_data0", rd(0), 32'h0);
            check("reclear_data1", rd(1), 32'h0);
        end

        repeat (400) begin
            randomize_inputs();
            step();
        end

        idle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Multi-port integer register file for the core's decode/writeback stages: NR combinational read ports, NW synchronous write ports, register 0 hard-wired to zero, a per-register pending scoreboard for hazard detection, and a post-reset clear sequencer that zeroes the array before the core may issue. It is the parametrised successor of the single-write, dual-read file, supporting multi-issue pipelines and optional write-to-read forwarding.

## Interface
- WIDTH, 32, data width in bits
- ADDR_WIDTH, 5, register address width
- DEPTH, 32, number of registers (≤ 2**ADDR_WIDTH)
- NR, 2, number of read ports
- NW, 1, number of write ports
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- ready  output  1  high once the clear sequence has completed
- rd_addr  input  NR*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_dout  output  NR*WIDTH  packed read data
- rd_pending  output  NR  scoreboard bit of each read port's address
- wr_en  input  NW  per-port write enable
- wr_addr  input  NW*ADDR_WIDTH  packed write addresses
- wr_din  input  NW*WIDTH  packed write data
- issue_en  input  1  mark issue_addr pending (destination allocated)
- issue_addr  input  ADDR_WIDTH  register to mark pending

## Operation
- Reset (rst=0): ready=0, all pending bits 0, clear counter 0, FSM in CLEAR; array contents not reset directly.
- FSM states: CLEAR → RUN. In CLEAR, one register per cycle at index = counter is written 0; counter increments; after writing DEPTH-1, next state RUN, ready=1. RUN is terminal until rst.
- In CLEAR: wr_en and issue_en ignored; rd_dout forced to 0; rd_pending forced to 0.
- Reads: rd_dout[i] = 0 if rd_addr[i]==0, else array[rd_addr[i]]; rd_pending[i] = pending[rd_addr[i]]. Out-of-range address (≥ DEPTH) reads 0, pending 0.
- Writes: each port with wr_en=1 and wr_addr≠0 and wr_addr<DEPTH writes wr_din at the clock edge and clears pending[wr_addr].
- Same-address write collision between ports: highest-index port wins.
- issue_en=1 with issue_addr≠0 sets pending[issue_addr]. Set and clear of the same register in one cycle: set wins (new producer allocated).
- pending[0] is constant 0; writes to register 0 are discarded.

## Timing
- Read data and rd_pending: combinational from rd_addr and current state, zero latency.
- Write: visible on reads the cycle after the edge (no bypass build).
- Scoreboard updates take effect at the edge; visible the next cycle.
- Clear: ready rises exactly DEPTH cycles after the first rising edge with rst=1.
- rst asserted mid-clear or mid-operation: immediately ready=0, pending cleared, FSM to CLEAR, counter 0; clear restarts from index 0.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, a read whose address matches an active write port in the same cycle returns that port's wr_din (highest matching port index) and rd_pending reads 0 unless issue_en sets the same address that cycle; register 0 still reads 0.
- Undefined: no forwarding; same-cycle reads return the old array value and old pending bit.

## Structure
- Package regfile_pkg: default WIDTH/ADDR_WIDTH/DEPTH constants, FSM state enumeration (CLEAR, RUN).
- Sub-module regfile_clear_seq: CLEAR/RUN FSM plus counter; outputs ready, clr_we, clr_addr. Array, write arbitration, scoreboard and read muxes stay in regfile_mp.

## Test plan
- Reset release, DEPTH=32 → ready=0 for 32 cycles, rises on cycle 32; all reads return 0; writes issued during CLEAR have no effect.
- RUN, write port 0 x5=0xDEADBEEF, next cycle read x5 on port 1 → 0xDEADBEEF; write x0=0x1234 → x0 reads 0.
- NW=2, both ports write x7 (0x11, 0x22) same cycle → x7 reads 0x22.
- issue_en x9 → rd_pending=1 next cycle; writeback x9 with simultaneous issue x9 → pending stays 1; writeback alone → pending 0.
- REGFILE_BYPASS_EN: write x3=0xA5A5A5A5 while reading x3 same cycle → 0xA5A5A5A5; without macro → old value.
- rst pulsed low mid-RUN after writes → ready=0, pending all 0, clear restarts, all registers read 0 after DEPTH cycles.
